// File: rtl/uart_rx.sv
// Unbuffered UART receiver: 2-flop rx synchroniser, mid-bit sampling, one-cycle valid/frame_err strobes.
// Optional even parity bit between data and stop bits when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int DATA_BITS      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);
    // state     | meaning
    // IDLE      | line idle, waiting for rx_s falling to 0
    // START     | timing half a bit to re-check the start bit
    // DATA      | sampling DATA_BITS data bits, LSB first
    // PARITY    | sampling the even-parity bit (parity build only)
    // STOP      | sampling the stop bit, strobing valid or frame_err
    // WAIT_IDLE | after a framing error, waiting for the line to go high
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    localparam int HALF = CLOCKS_PER_BIT / 2;
    localparam int BW   = $clog2(CLOCKS_PER_BIT);
    localparam int NW   = $clog2(DATA_BITS + 3);
    localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLOCKS_PER_BIT - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);

    state_t               state, state_nxt;
    logic                 rx_m, rx_s;
    logic [BW-1:0]        baud_cnt, baud_nxt;
    logic [NW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt, shift_in, data_nxt;
    logic                 valid_nxt, ferr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // New bit enters at the MSB so the word is in order after the last data bit.
    if (DATA_BITS > 1) begin : g_shift
        assign shift_in = {rx_s, shift_reg[DATA_BITS-1:1]};
    end else begin : g_shift_one
        assign shift_in = rx_s;
    end

    assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_bit_nxt, perr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bit    <= par_bit_nxt;
            parity_err <= perr_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + BW'(1);
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        data_nxt  = data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt = par_bit;
        perr_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                baud_nxt = '0;
                bit_nxt  = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_nxt  = '0;
                    shift_nxt = shift_in;
                    bit_nxt   = bit_cnt + NW'(1);
                    if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_nxt    = '0;
                    bit_nxt     = bit_cnt + NW'(1);
                    par_bit_nxt = rx_s;
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_nxt = '0;
                    if (rx_s) begin
                        data_nxt  = shift_reg;
                        valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_nxt  = (^shift_reg) ^ par_bit;
`endif
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                baud_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are driven at the pin and strobes are predicted from frame timing.
module tb_uart_rx;
    localparam int CPB  = 4;
    localparam int DB   = 8;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NSTOP      = PAR_EN ? DB + 2 : DB + 1;
    localparam int STROBE_OFS = 2 + HALF + NSTOP * CPB + 1;
    localparam int FRAME_LEN  = (NSTOP + 1) * CPB;

    typedef struct {
        int          cyc;
        bit          good;
        logic [DB-1:0] word;
        bit          perr;
    } ev_t;

    logic          clk, rst, rx;
    logic [DB-1:0] data;
    logic          valid, frame_err, parity_err, busy;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    ev_t           evq[$];
    logic [DB-1:0] model_data = '0;
    int            last_valid_cyc = 0;
    int            prev_valid_cyc = 0;

    uart_rx #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a clock edge; the strobe is predicted from the pin cycle of the falling edge.
    task automatic send_frame(input logic [DB-1:0] w, input bit stop, input int hold_low, input bit pbit);
        ev_t ev;
        ev.cyc  = cyc + STROBE_OFS;
        ev.good = stop;
        ev.word = w;
        ev.perr = PAR_EN && stop && ((^w) ^ pbit);
        evq.push_back(ev);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < DB; i++) begin
            rx = w[i];
            wait_cyc(CPB);
        end
        if (PAR_EN) begin
            rx = pbit;
            wait_cyc(CPB);
        end
        rx = stop;
        wait_cyc(CPB);
        if (!stop) wait_cyc(hold_low);
    endtask

    always @(negedge clk) begin
        bit exp_v, exp_f, exp_p;
        ev_t ev;
        exp_v = 1'b0;
        exp_f = 1'b0;
        exp_p = 1'b0;
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
            ev = evq.pop_front();
            exp_v = ev.good;
            exp_f = !ev.good;
            exp_p = ev.perr;
            if (ev.good) model_data = ev.word;
        end
        if (valid || exp_v) check("valid", 32'(valid), 32'(exp_v));
        if (frame_err || exp_f) check("frame_err", 32'(frame_err), 32'(exp_f));
        if (parity_err || exp_p) check("parity_err", 32'(parity_err), 32'(exp_p));
        if (exp_v || exp_f) check("data", 32'(data), 32'(model_data));
        if (exp_v) check("busy_at_valid", 32'(busy), 32'd0);
        if (exp_f) check("busy_at_frame_err", 32'(busy), 32'd1);
        if (valid) begin
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        rst = 1'b1;
        rx  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_frame_err", 32'(frame_err), 32'd0);
            check("rst_data", 32'(data), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx  = 1'b1;
        wait_cyc(10);
        check("idle_busy", 32'(busy), 32'd0);

        send_frame(8'hA5, 1'b1, 0, 1'b0);
        wait_cyc(3);

        send_frame(8'h00, 1'b1, 0, 1'b0);
        send_frame(8'hFF, 1'b1, 0, 1'b0);
        wait_cyc(5);
        check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(FRAME_LEN));

        rx = 1'b0;
        wait_cyc(1);
        rx = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("glitch_busy_seen", 32'(n > 0), 32'd1);
        check("glitch_busy_len_ok", 32'(n <= HALF + 1), 32'd1);
        @(posedge clk);
        #1;

        send_frame(8'h3C, 1'b0, 20, 1'b0);
        check("ferr_busy_hold", 32'(busy), 32'd1);
        rx = 1'b1;
        n = 0;
        while (busy && n < 10) begin
            wait_cyc(1);
            n++;
        end
        check("ferr_busy_release", 32'(busy), 32'd0);
        check("ferr_release_time_ok", 32'(n <= 4), 32'd1);
        wait_cyc(2);

        r = 8'h77;
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = r[i];
            wait_cyc(CPB);
        end
        rx = r[4];
        wait_cyc(HALF);
        check("midreset_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        rx  = 1'b1;
        wait_cyc(1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_data", 32'(data), 32'd0);
        check("midreset_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        model_data = '0;
        wait_cyc(6);

        send_frame(8'h5A, 1'b1, 0, 1'b1);
        wait_cyc(3);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rx = 1'b0;
                wait_cyc(1);
                rx = 1'b1;
                wait_cyc(HALF + 3);
            end else if (r == 1) begin
                send_frame(DB'($urandom), 1'b0, $urandom_range(0, 8), 1'($urandom));
                rx = 1'b1;
                wait_cyc(3);
            end else begin
                send_frame(DB'($urandom), 1'b1, 0, 1'($urandom));
                wait_cyc($urandom_range(0, 3));
            end
        end

        wait_cyc(STROBE_OFS + 20);
        check("events_drained", 32'(evq.size()), 32'd0);
        check("final_data", 32'(data), 32'(model_data));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
